wb_io_master: RTL and testbench

- CPU-side Wishbone master for J1 I/O accesses. Converts a single-request valid/ready port into Wishbone classic pipelined bus cycles and returns read data or an error.
- Sits directly upstream of the Wishbone I/O slave and drives its cyc/stb/we/adr/dat and consumes its ack/stall/dat.
- One outstanding transaction. Bus timeout guards against a missing ack.

---
 rtl/wb_io_master_pkg.sv | 18 +
 rtl/wb_io_master_timeout.sv | 42 ++++
 rtl/wb_io_master.sv | 159 +++++++++++++++
 tb/tb_wb_io_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_io_master_pkg.sv
// wb_io_master_pkg
//   Shared types and constants for the J1 I/O Wishbone master.
//   - state_e   : bridge FSM states (IDLE, REQ, WAIT)
//   - DAT_W     : Wishbone data width
//   - ERR_RDATA : value returned on rsp_dat when a cycle times out
package wb_io_master_pkg;

  localparam int unsigned DAT_W = 16;

  localparam logic [DAT_W-1:0] ERR_RDATA = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/wb_io_master_timeout.sv
// wb_timeout
//   Bus-cycle watchdog counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : clear the count (start of a new bus cycle)
//   en         : count one cycle (saturates at TIMEOUT, never wraps)
//   expired    : count has reached TIMEOUT (always 0 when TIMEOUT == 0)
module wb_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == TC);

endmodule

// File: rtl/wb_io_master.sv
// wb_io_master
//   CPU-side Wishbone (classic pipelined) master for J1 I/O accesses.
//   One outstanding transaction; a watchdog ends cycles the slave never acks.
//   CPU side : req_valid/req_ready/req_we/req_adr/req_dat in,
//              rsp_valid (1-cycle pulse) / rsp_dat (held) / rsp_err out
//   Bus side : wb_cyc/wb_stb/wb_we/wb_adr/wb_dat_o out,
//              wb_dat_i/wb_ack/wb_stall in
//   All wb_* and rsp_* outputs are registered.
module wb_io_master
  import wb_io_master_pkg::*;
#(
  parameter int unsigned ADR_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [DAT_W-1:0] req_dat,
  output logic             rsp_valid,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [ADR_W-1:0] wb_adr,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_ack,
  input  logic             wb_stall
);

  state_e             state_q,     state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0]   rsp_dat_q,   rsp_dat_d;
  logic               rsp_err_q,   rsp_err_d;
  logic               wb_cyc_q,    wb_cyc_d;
  logic               wb_stb_q,    wb_stb_d;
  logic               wb_we_q,     wb_we_d;
  logic [ADR_W-1:0]   wb_adr_q,    wb_adr_d;
  logic [DAT_W-1:0]   wb_dat_o_q,  wb_dat_o_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_expired;
  logic ack_seen;

  wb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // An ack only counts once the strobe has been taken (not stalled) or while
  // waiting; a zero-latency slave acks in REQ with stall low.
  assign ack_seen = wb_ack && ((state_q == WAIT) || ((state_q == REQ) && !wb_stall));
  assign tmr_en   = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    wb_cyc_d    = wb_cyc_q;
    wb_stb_d    = wb_stb_q;
    wb_we_d     = wb_we_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_o_d  = wb_dat_o_q;
    tmr_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wb_we_d     = req_we;
          wb_adr_d    = req_adr;
          wb_dat_o_d  = req_dat;
          wb_cyc_d    = 1'b1;
          wb_stb_d    = 1'b1;
          req_ready_d = 1'b0;
          tmr_load    = 1'b1;
          state_d     = REQ;
        end
      end
      REQ, WAIT: begin
        // Ack beats a timeout landing in the same cycle.
        if (ack_seen) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!wb_we_q) begin
            rsp_dat_d = wb_dat_i;
          end
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else if (tmr_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = ERR_RDATA;
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else if ((state_q == REQ) && !wb_stall) begin
          wb_stb_d = 1'b0;
          state_d  = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_o_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_o_q  <= wb_dat_o_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_stb_q;
  assign wb_we     = wb_we_q;
  assign wb_adr    = wb_adr_q;
  assign wb_dat_o  = wb_dat_o_q;

endmodule

// File: tb/tb_wb_io_master.sv
// tb_wb_io_master
//   Self-checking bench for wb_io_master (TIMEOUT = 8). A configurable slave
//   model (no ack / registered ack / zero-latency ack, N stall cycles) serves
//   the bus; expected responses are queued at request time and checked when
//   rsp_valid appears, including the latency measured from the accept edge.
module tb_wb_io_master;

  localparam int unsigned ADR_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [ADR_W-1:0] req_adr = '0;
  logic [15:0]      req_dat = '0;
  logic             rsp_valid;
  logic [15:0]      rsp_dat;
  logic             rsp_err;
  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [ADR_W-1:0] wb_adr;
  logic [15:0]      wb_dat_o;
  logic [15:0]      wb_dat_i;
  logic             wb_ack;
  logic             wb_stall;

  always #5 clk = ~clk;

  wb_io_master #(
    .ADR_W   (ADR_W),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .rsp_valid (rsp_valid),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack    (wb_ack),
    .wb_stall  (wb_stall)
  );

  // Slave model. mode: 0 = never acks, 1 = ack registered one cycle after an
  // accepted strobe, 2 = zero-latency ack. force_ack injects arbitrary acks.
  int unsigned mode = 0;
  int unsigned stall_cfg = 0;
  int unsigned stall_cnt = 0;
  logic        ack_r = 1'b0;
  logic        force_ack = 1'b0;
  logic        b2b = 1'b0;
  logic [15:0] slave_rdata = '0;

  assign wb_stall = wb_stb && (stall_cnt < stall_cfg);
  assign wb_ack   = force_ack || ((mode == 1) && ack_r) ||
                    ((mode == 2) && wb_stb && !wb_stall);
  assign wb_dat_i = b2b ? ~wb_adr : slave_rdata;

  always @(posedge clk) begin
    ack_r     <= (mode == 1) && wb_stb && !wb_stall;
    stall_cnt <= wb_stb ? stall_cnt + 1 : 0;
  end

  typedef struct {
    logic [15:0] dat;
    logic        err;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] rdata;
    int unsigned stall;
    int unsigned mode;
    int unsigned lat;
    logic [15:0] exp_dat;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc_n = 0;
  int unsigned last_rsp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic push(input logic [15:0] dat, input logic err, input int unsigned lat);
    exp_t e;
    e.dat = dat;
    e.err = err;
    e.lat = lat;
    e.acc = cyc_n + 1;
    sb.push_back(e);
  endtask

  // One clock; observe 1 time unit after the edge and score any response.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rsp_valid === 1'b1) begin
      last_rsp = cyc_n;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("rsp_dat", 32'(rsp_dat), 32'(e.dat));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", cyc_n - e.acc + 1, e.lat);
      end
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (req_ready !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    chk("ready_wait", 32'(req_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    vec_t        v;
    int unsigned stb_n;
    int unsigned cyc_hi;
    int          g;
    int unsigned prev;
    logic [15:0] a;

    vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'hA5C3, 0, 1, 3, 16'hA5C3};
    vecs[1] = '{1'b1, 16'h0004, 16'h1234, 16'hDEAD, 4, 1, 7, 16'hA5C3};
    vecs[2] = '{1'b0, 16'h0020, 16'h0000, 16'h5A3C, 0, 2, 2, 16'h5A3C};
    vecs[3] = '{1'b1, 16'h0030, 16'hFFFF, 16'h7777, 0, 2, 2, 16'h5A3C};
    vecs[4] = '{1'b0, 16'h0040, 16'h0000, 16'h0001, 2, 2, 4, 16'h0001};
    vecs[5] = '{1'b0, 16'h0050, 16'h0000, 16'hBEEF, 1, 1, 4, 16'hBEEF};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_wb_cyc",    32'(wb_cyc),    32'(0));
    chk("rst_wb_stb",    32'(wb_stb),    32'(0));
    chk("rst_wb_we",     32'(wb_we),     32'(0));
    chk("rst_wb_adr",    32'(wb_adr),    32'(0));
    chk("rst_wb_dat_o",  32'(wb_dat_o),  32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_dat",   32'(rsp_dat),   32'(0));
    chk("rst_rsp_err",   32'(rsp_err),   32'(0));
    rst_n = 1'b1;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      wait_ready();
      mode        = v.mode;
      stall_cfg   = v.stall;
      slave_rdata = v.rdata;
      req_valid   = 1'b1;
      req_we      = v.we;
      req_adr     = v.adr;
      req_dat     = v.dat;
      push(v.exp_dat, 1'b0, v.lat);
      tick();
      req_valid = 1'b0;
      chk("accept_cyc", 32'(wb_cyc), 32'(1));
      chk("accept_stb", 32'(wb_stb), 32'(1));
      chk("accept_we",  32'(wb_we),  32'(v.we));
      chk("accept_adr", 32'(wb_adr), 32'(v.adr));
      chk("accept_ready_low", 32'(req_ready), 32'(0));
      if (v.we) chk("accept_dat_o", 32'(wb_dat_o), 32'(v.dat));
      stb_n = 32'(wb_stb);
      g = 0;
      while (sb.size() != 0 && g < 40) begin
        tick();
        if (wb_stb) begin
          stb_n++;
          chk("stb_adr_hold", 32'(wb_adr), 32'(v.adr));
          chk("stb_dat_hold", 32'(wb_dat_o), 32'(v.dat));
        end
        g++;
      end
      chk("rsp_seen", 32'(sb.size()), 32'(0));
      sb.delete();
      chk("stb_cycles", stb_n, v.stall + 1);
      chk("done_ready", 32'(req_ready), 32'(1));
      chk("done_cyc",   32'(wb_cyc),    32'(0));
    end

    // Timeout: slave never acks
    wait_ready();
    mode      = 0;
    stall_cfg = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = 16'h0060;
    push(16'h0000, 1'b1, 10);
    tick();
    req_valid = 1'b0;
    cyc_hi = 32'(wb_cyc);
    g = 0;
    while (sb.size() != 0 && g < 40) begin
      tick();
      if (wb_cyc) cyc_hi++;
      g++;
    end
    chk("to_rsp_seen", 32'(sb.size()), 32'(0));
    sb.delete();
    chk("to_cyc_cycles", cyc_hi, 9);
    chk("to_stb_low", 32'(wb_stb), 32'(0));
    // Stray acks in IDLE
    force_ack = 1'b1;
    tick();
    chk("stray_rsp_valid", 32'(rsp_valid), 32'(0));
    tick();
    force_ack = 1'b0;
    chk("stray_rsp_valid2", 32'(rsp_valid), 32'(0));
    chk("stray_cyc", 32'(wb_cyc), 32'(0));
    tick();
    chk("stray_rsp_valid3", 32'(rsp_valid), 32'(0));

    // Ack arriving in the same cycle as the timeout wins
    wait_ready();
    slave_rdata = 16'hC0DE;
    req_valid   = 1'b1;
    req_adr     = 16'h0070;
    push(16'hC0DE, 1'b0, 10);
    tick();
    req_valid = 1'b0;
    repeat (8) tick();
    chk("tie_cyc_before", 32'(wb_cyc), 32'(1));
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("tie_rsp_seen", 32'(sb.size()), 32'(0));
    sb.delete();
    chk("tie_cyc_after", 32'(wb_cyc), 32'(0));

    // Back-to-back reads with req_valid held high
    wait_ready();
    mode      = 1;
    b2b       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    prev      = 0;
    for (int i = 0; i < 3; i++) begin
      a = 16'((i + 1) * 256);
      req_adr = a;
      push(~a, 1'b0, 3);
      tick();
      if (i == 2) req_valid = 1'b0;
      tick();
      tick();
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("b2b_ready", 32'(req_ready), 32'(1));
      if (i > 0) chk("b2b_spacing", last_rsp - prev, 3);
      prev = last_rsp;
    end
    chk("b2b_all_seen", 32'(sb.size()), 32'(0));
    sb.delete();
    b2b = 1'b0;
    tick();
    chk("b2b_idle_cyc", 32'(wb_cyc), 32'(0));

    // Reset while in WAIT, then a late ack
    wait_ready();
    mode      = 0;
    req_valid = 1'b1;
    req_adr   = 16'h0080;
    tick();
    req_valid = 1'b0;
    tick();
    chk("wait_cyc", 32'(wb_cyc), 32'(1));
    chk("wait_stb", 32'(wb_stb), 32'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_cyc",       32'(wb_cyc),    32'(0));
    chk("midrst_stb",       32'(wb_stb),    32'(0));
    chk("midrst_ready",     32'(req_ready), 32'(1));
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("midrst_rsp_dat",   32'(rsp_dat),   32'(0));
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("late_ack_rsp_valid", 32'(rsp_valid), 32'(0));
    tick();
    chk("late_ack_rsp_valid2", 32'(rsp_valid), 32'(0));
    chk("late_ack_cyc", 32'(wb_cyc), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
